// File: rtl/dcache_flush_pkg.sv
// Shared types for the dcache flush sequencer: cache geometry config, walk states
// and the terminal-line predicate used by the set/way counter.
package dcache_flush_pkg;

  typedef struct packed {
    int unsigned DCACHE_NUM_WORDS;
    int unsigned DCACHE_SET_ASSOC;
    int unsigned DCACHE_SET_ASSOC_WIDTH;
    bit          DcacheInvalidateOnFlush;
  } flush_cfg_t;

  // 32 KiB, 8-way, 128-bit lines
  localparam flush_cfg_t DcacheFlushCfgDefault = '{
    DCACHE_NUM_WORDS:        32'd256,
    DCACHE_SET_ASSOC:        32'd8,
    DCACHE_SET_ASSOC_WIDTH:  32'd3,
    DcacheInvalidateOnFlush: 1'b1
  };

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_REQ,
    RD_WAIT,
    WB_REQ,
    WB_WAIT,
    WR,
    ACK
  } flush_state_e;

  function automatic logic last_line(input int idx, input int way, input int nw, input int na);
    return (idx == nw - 1) && (way == na - 1);
  endfunction

endpackage

// File: rtl/flush_walk_cnt.sv
// Set/way walk counter: way is the fast-moving digit, terminal flags are evaluated
// on the current value so the owner can stop before any wrap past the last set.
module flush_walk_cnt
  import dcache_flush_pkg::*;
#(
  parameter int NW   = 256,
  parameter int NA   = 8,
  parameter int IdxW = 8,
  parameter int WayW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_idx_i,
  input  logic            inc_way_i,
  output logic [IdxW-1:0] idx_o,
  output logic [WayW-1:0] way_o,
  output logic            idx_last_o,
  output logic            last_o
);

  logic [IdxW-1:0] idx_q;
  logic [WayW-1:0] way_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      idx_q <= '0;
      way_q <= '0;
    end else if (inc_idx_i) begin
      idx_q <= idx_q + IdxW'(1);
    end else if (inc_way_i) begin
      if (way_q == WayW'(NA - 1)) begin
        way_q <= '0;
        idx_q <= idx_q + IdxW'(1);
      end else begin
        way_q <= way_q + WayW'(1);
      end
    end
  end

  assign idx_o      = idx_q;
  assign way_o      = way_q;
  assign idx_last_o = (idx_q == IdxW'(NW - 1));
  assign last_o     = last_line(int'(idx_q), int'(way_q), NW, NA);

endmodule

// File: rtl/dcache_flush_seq.sv
// Dcache flush sequencer: invalidates the tag/state array after reset and, on a
// flush request, writes back dirty lines and clears state for every set and way.
module dcache_flush_seq
  import dcache_flush_pkg::*;
#(
  parameter flush_cfg_t CVA6Cfg = DcacheFlushCfgDefault,
  localparam int NW   = int'(CVA6Cfg.DCACHE_NUM_WORDS),
  localparam int NA   = int'(CVA6Cfg.DCACHE_SET_ASSOC),
  localparam int IdxW = $clog2(NW),
  localparam int WayW = int'(CVA6Cfg.DCACHE_SET_ASSOC_WIDTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  output logic            flush_ack_o,
  output logic            busy_o,
  output logic            sram_req_o,
  output logic            sram_we_o,
  output logic [IdxW-1:0] sram_idx_o,
  output logic [NA-1:0]   sram_way_o,
  input  logic            sram_gnt_i,
  input  logic            sram_rvalid_i,
  input  logic            sram_valid_i,
  input  logic            sram_dirty_i,
  output logic            sram_wvalid_o,
  output logic            sram_wdirty_o,
  output logic            wb_req_o,
  output logic [IdxW-1:0] wb_idx_o,
  output logic [WayW-1:0] wb_way_o,
  input  logic            wb_gnt_i,
  input  logic            wb_done_i
);

  localparam bit INV = CVA6Cfg.DcacheInvalidateOnFlush;

  flush_state_e    state_q, state_d;
  logic            valid_q, valid_d;
  logic            cnt_clr, cnt_inc_idx, cnt_inc_way, step;
  logic [IdxW-1:0] idx;
  logic [WayW-1:0] way;
  logic            idx_last, last;

  flush_walk_cnt #(
    .NW  (NW),
    .NA  (NA),
    .IdxW(IdxW),
    .WayW(WayW)
  ) u_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .inc_idx_i (cnt_inc_idx),
    .inc_way_i (cnt_inc_way),
    .idx_o     (idx),
    .way_o     (way),
    .idx_last_o(idx_last),
    .last_o    (last)
  );

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cnt_clr     = 1'b0;
    cnt_inc_idx = 1'b0;
    cnt_inc_way = 1'b0;
    step        = 1'b0;
    case (state_q)
      INIT: begin
        if (sram_gnt_i) begin
          if (idx_last) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc_idx = 1'b1;
          end
        end
      end
      IDLE: begin
        if (flush_i) begin
          state_d = RD_REQ;
          cnt_clr = 1'b1;
        end
      end
      RD_REQ:  if (sram_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (sram_rvalid_i) begin
          valid_d = sram_valid_i;
          if (sram_valid_i && sram_dirty_i) state_d = WB_REQ;
          else if (sram_valid_i && INV)     state_d = WR;
          else                              step    = 1'b1;
        end
      end
      WB_REQ:  if (wb_gnt_i) state_d = WB_WAIT;
      WB_WAIT: if (wb_done_i) state_d = WR;
      WR:      if (sram_gnt_i) step = 1'b1;
      ACK:     state_d = IDLE;
      default: state_d = INIT;
    endcase
    // Advancing to the next line folds into the transition; no dedicated cycle.
    if (step) begin
      if (last) begin
        state_d = ACK;
      end else begin
        state_d     = RD_REQ;
        cnt_inc_way = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Outputs decode only the registered state and counters.
  always_comb begin
    sram_req_o    = 1'b0;
    sram_we_o     = 1'b0;
    sram_way_o    = '0;
    sram_wvalid_o = 1'b0;
    sram_wdirty_o = 1'b0;
    case (state_q)
      INIT: begin
        sram_req_o = 1'b1;
        sram_we_o  = 1'b1;
        sram_way_o = '1;
      end
      RD_REQ: begin
        sram_req_o = 1'b1;
        sram_way_o = NA'(1) << way;
      end
      WR: begin
        sram_req_o    = 1'b1;
        sram_we_o     = 1'b1;
        sram_way_o    = NA'(1) << way;
        sram_wvalid_o = INV ? 1'b0 : valid_q;
      end
      default: ;
    endcase
  end

  assign sram_idx_o  = idx;
  assign wb_req_o    = (state_q == WB_REQ);
  assign wb_idx_o    = idx;
  assign wb_way_o    = way;
  assign busy_o      = (state_q != IDLE);
  assign flush_ack_o = (state_q == ACK);

endmodule

// File: tb/tb_dcache_flush_seq.sv
// Directed bench: instance A (256 sets x 8 ways, invalidate on flush) and
// instance B (4 sets x 2 ways, keep clean lines) against a line-state model.
module tb_dcache_flush_seq;
  import dcache_flush_pkg::*;

  localparam flush_cfg_t CfgA = '{DCACHE_NUM_WORDS: 256, DCACHE_SET_ASSOC: 8,
                                  DCACHE_SET_ASSOC_WIDTH: 3, DcacheInvalidateOnFlush: 1'b1};
  localparam flush_cfg_t CfgB = '{DCACHE_NUM_WORDS: 4, DCACHE_SET_ASSOC: 2,
                                  DCACHE_SET_ASSOC_WIDTH: 1, DcacheInvalidateOnFlush: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst = 1'b1;
  int checks = 0, failures = 0;

  // instance A signals
  logic a_flush = 0, a_ack, a_busy, a_req, a_we, a_wvalid, a_wdirty, a_wb_req;
  logic [7:0] a_idx, a_way, a_wb_idx;
  logic [2:0] a_wb_way;
  logic a_gnt = 1, a_rvalid = 0, a_vbit = 0, a_dbit = 0, a_wb_gnt = 0, a_wb_done = 0;
  // instance B signals
  logic b_flush = 0, b_ack, b_busy, b_req, b_we, b_wvalid, b_wdirty, b_wb_req;
  logic [1:0] b_idx, b_way, b_wb_idx;
  logic [0:0] b_wb_way;
  logic b_gnt = 1, b_rvalid = 0, b_vbit = 0, b_dbit = 0, b_wb_gnt = 0, b_wb_done = 0;

  dcache_flush_seq #(.CVA6Cfg(CfgA)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .flush_ack_o(a_ack), .busy_o(a_busy),
    .sram_req_o(a_req), .sram_we_o(a_we), .sram_idx_o(a_idx), .sram_way_o(a_way),
    .sram_gnt_i(a_gnt), .sram_rvalid_i(a_rvalid), .sram_valid_i(a_vbit), .sram_dirty_i(a_dbit),
    .sram_wvalid_o(a_wvalid), .sram_wdirty_o(a_wdirty), .wb_req_o(a_wb_req), .wb_idx_o(a_wb_idx),
    .wb_way_o(a_wb_way), .wb_gnt_i(a_wb_gnt), .wb_done_i(a_wb_done));

  dcache_flush_seq #(.CVA6Cfg(CfgB)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .flush_ack_o(b_ack), .busy_o(b_busy),
    .sram_req_o(b_req), .sram_we_o(b_we), .sram_idx_o(b_idx), .sram_way_o(b_way),
    .sram_gnt_i(b_gnt), .sram_rvalid_i(b_rvalid), .sram_valid_i(b_vbit), .sram_dirty_i(b_dbit),
    .sram_wvalid_o(b_wvalid), .sram_wdirty_o(b_wdirty), .wb_req_o(b_wb_req), .wb_idx_o(b_wb_idx),
    .wb_way_o(b_wb_way), .wb_gnt_i(b_wb_gnt), .wb_done_i(b_wb_done));

  // line-state models and monitor counters
  bit a_mem_v [256][8], a_mem_d [256][8];
  bit b_mem_v [4][2], b_mem_d [4][2];
  logic a_rd_pend = 0, a_stall_prev = 0, a_prev_we = 0, a_prev_wvalid = 0, a_busy_prev = 1;
  logic a_bp = 0, a_after_wb = 0;
  logic [7:0] a_prev_idx = 0, a_prev_way = 0, a_pidx = 0, a_rd_after_idx = 0, a_wb_last_idx = 0;
  logic [2:0] a_pway = 0, a_rd_after_way = 0, a_wb_last_way = 0;
  int a_init_cnt = 0, a_init_exp = 0, a_init_bad = 0, a_rd_cnt = 0, a_wr_cnt = 0, a_wr_bad = 0;
  int a_wb_cnt = 0, a_wb_timer = 0, a_ack_cnt = 0, a_ack_cyc = 0, a_start_cyc = 0, a_stab_err = 0;
  logic b_rd_pend = 0, b_busy_prev = 1;
  logic [1:0] b_pidx = 0;
  logic [0:0] b_pway = 0;
  int b_rd_cnt = 0, b_wr_cnt = 0, b_wr_bad = 0, b_wb_cnt = 0, b_wb_timer = 0;
  int b_ack_cnt = 0, b_ack_cyc = 0, b_start_cyc = 0;

  // Responder and monitor for A: runs on the falling edge, drives the inputs seen
  // at the next rising edge and logs every granted access.
  always @(negedge clk) begin
    if (rst) begin
      a_rd_pend = 0; a_rvalid = 0; a_vbit = 0; a_dbit = 0; a_gnt = 1; a_stall_prev = 0;
    end else begin
      a_rvalid = a_rd_pend;
      a_vbit = a_rd_pend && a_mem_v[a_pidx][a_pway];
      a_dbit = a_rd_pend && a_mem_d[a_pidx][a_pway];
      if (a_stall_prev && !(a_req && a_we == a_prev_we && a_idx == a_prev_idx &&
                            a_way == a_prev_way && a_wvalid == a_prev_wvalid))
        a_stab_err++;
      a_gnt = a_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      a_rd_pend = 0;
      if (a_req && a_gnt) begin
        if (a_we && a_way == 8'hFF) begin
          if (a_idx != 8'(a_init_exp) || a_wvalid || a_wdirty) a_init_bad++;
          a_init_exp++; a_init_cnt++;
        end else if (a_we) begin
          a_wr_cnt++;
          if (a_wvalid || a_wdirty || !$onehot(a_way)) a_wr_bad++;
        end else begin
          a_rd_cnt++;
          a_rd_pend = 1; a_pidx = a_idx;
          for (int w = 0; w < 8; w++) if (a_way[w]) a_pway = 3'(w);
          if (a_after_wb) begin a_after_wb = 0; a_rd_after_idx = a_idx; a_rd_after_way = a_pway; end
        end
        if (a_we)
          for (int w = 0; w < 8; w++)
            if (a_way[w]) begin a_mem_v[a_idx][w] = a_wvalid; a_mem_d[a_idx][w] = a_wdirty; end
      end
      a_stall_prev = a_req && !a_gnt;
      a_prev_we = a_we; a_prev_idx = a_idx; a_prev_way = a_way; a_prev_wvalid = a_wvalid;
      if (a_ack) begin a_ack_cnt++; a_ack_cyc = cyc; end
      if (a_busy && !a_busy_prev) a_start_cyc = cyc;
    end
    a_busy_prev = a_busy;
    // writeback unit keeps counting through reset so a stale done can arrive later
    a_wb_done = 0;
    if (a_wb_timer != 0) begin a_wb_timer--; a_wb_done = (a_wb_timer == 0); end
    a_wb_gnt = a_wb_req;
    if (a_wb_req && !rst) begin
      a_wb_cnt++; a_wb_last_idx = a_wb_idx; a_wb_last_way = a_wb_way; a_wb_timer = 10; a_after_wb = 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_rd_pend = 0; b_rvalid = 0; b_vbit = 0; b_dbit = 0; b_gnt = 1;
    end else begin
      b_rvalid = b_rd_pend;
      b_vbit = b_rd_pend && b_mem_v[b_pidx][b_pway];
      b_dbit = b_rd_pend && b_mem_d[b_pidx][b_pway];
      b_gnt = 1'b1;
      b_rd_pend = 0;
      if (b_req) begin
        if (b_we && b_way != 2'b11) begin
          b_wr_cnt++;
          if (!b_wvalid || b_wdirty || !$onehot(b_way)) b_wr_bad++;
        end else if (!b_we) begin
          b_rd_cnt++; b_rd_pend = 1; b_pidx = b_idx; b_pway = b_way[1] ? 1'b1 : 1'b0;
        end
        if (b_we)
          for (int w = 0; w < 2; w++)
            if (b_way[w]) begin b_mem_v[b_idx][w] = b_wvalid; b_mem_d[b_idx][w] = b_wdirty; end
      end
      if (b_ack) begin b_ack_cnt++; b_ack_cyc = cyc; end
      if (b_busy && !b_busy_prev) b_start_cyc = cyc;
    end
    b_busy_prev = b_busy;
    b_wb_done = 0;
    if (b_wb_timer != 0) begin b_wb_timer--; b_wb_done = (b_wb_timer == 0); end
    b_wb_gnt = b_wb_req;
    if (b_wb_req && !rst) begin b_wb_cnt++; b_wb_timer = 10; end
  end

  task automatic clear_a_counters();
    a_rd_cnt = 0; a_wr_cnt = 0; a_wr_bad = 0; a_wb_cnt = 0; a_ack_cnt = 0; a_stab_err = 0;
    a_init_cnt = 0; a_init_exp = 0; a_init_bad = 0; a_after_wb = 0;
  endtask

  task automatic fill_a_clean();
    for (int s = 0; s < 256; s++)
      for (int w = 0; w < 8; w++) begin a_mem_v[s][w] = 1; a_mem_d[s][w] = 0; end
  endtask

  task automatic pulse_a_flush();
    @(posedge clk); #1 a_flush = 1;
    @(posedge clk); #1 a_flush = 0;
  endtask

  task automatic wait_a_done(input int bound, output int n);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(a_ack_cnt > 0 && !a_busy) && n < bound);
  endtask

  task automatic wait_a_idle(input int bound, output int n);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (a_busy && n < bound);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0b want=1", a_busy); end
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b want=0", a_ack); end
    checks++; if (a_wb_req !== 1'b0) begin failures++; $display("FAIL reset_wb_req got=%0b want=0", a_wb_req); end
    checks++; if (a_req !== 1'b1 || a_we !== 1'b1) begin failures++; $display("FAIL reset_req got=%0b/%0b want=1/1", a_req, a_we); end
    checks++; if (a_way !== 8'hFF) begin failures++; $display("FAIL reset_way got=%h want=ff", a_way); end
    checks++; if (a_idx !== 8'd0) begin failures++; $display("FAIL reset_idx got=%0d want=0", a_idx); end
    $display("reset: busy=%0b ack=%0b req=%0b way=%h", a_busy, a_ack, a_req, a_way);
  endtask

  task automatic test_init();
    int n;
    @(posedge clk); #1 clear_a_counters(); rst = 0;
    wait_a_idle(400, n);
    checks++; if (n != 257) begin failures++; $display("FAIL init_idle_cycle got=%0d want=257", n); end
    checks++; if (a_init_cnt != 256) begin failures++; $display("FAIL init_writes got=%0d want=256", a_init_cnt); end
    checks++; if (a_init_bad != 0) begin failures++; $display("FAIL init_write_fields got=%0d bad want=0", a_init_bad); end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL init_b_idle got=%0b want=0", b_busy); end
    $display("init: writes=%0d idle_at_cycle=%0d", a_init_cnt, n);
  endtask

  task automatic test_inv_flush();
    int n;
    fill_a_clean(); clear_a_counters();
    pulse_a_flush();
    wait_a_done(7000, n);
    checks++; if (a_rd_cnt != 2048) begin failures++; $display("FAIL inv_reads got=%0d want=2048", a_rd_cnt); end
    checks++; if (a_wr_cnt != 2048) begin failures++; $display("FAIL inv_writes got=%0d want=2048", a_wr_cnt); end
    checks++; if (a_wr_bad != 0) begin failures++; $display("FAIL inv_write_fields got=%0d bad want=0", a_wr_bad); end
    checks++; if (a_wb_cnt != 0) begin failures++; $display("FAIL inv_wb_reqs got=%0d want=0", a_wb_cnt); end
    checks++; if (a_ack_cnt != 1) begin failures++; $display("FAIL inv_acks got=%0d want=1", a_ack_cnt); end
    checks++; if (a_ack_cyc - a_start_cyc + 1 != 6145) begin failures++; $display("FAIL inv_ack_latency got=%0d want=6145", a_ack_cyc - a_start_cyc + 1); end
    $display("inv_flush: reads=%0d writes=%0d ack_latency=%0d", a_rd_cnt, a_wr_cnt, a_ack_cyc - a_start_cyc + 1);
  endtask

  task automatic test_dirty_line();
    int n;
    fill_a_clean(); a_mem_d[5][3] = 1; clear_a_counters();
    pulse_a_flush();
    wait_a_done(7000, n);
    checks++; if (a_wb_cnt != 1) begin failures++; $display("FAIL dirty_wb_reqs got=%0d want=1", a_wb_cnt); end
    checks++; if (a_wb_last_idx != 8'd5 || a_wb_last_way != 3'd3) begin failures++; $display("FAIL dirty_wb_addr got=%0d/%0d want=5/3", a_wb_last_idx, a_wb_last_way); end
    checks++; if (a_wr_bad != 0 || a_wr_cnt != 2048) begin failures++; $display("FAIL dirty_writes got=%0d bad=%0d want=2048 bad=0", a_wr_cnt, a_wr_bad); end
    checks++; if (a_rd_after_idx != 8'd5 || a_rd_after_way != 3'd4) begin failures++; $display("FAIL dirty_resume got=%0d/%0d want=5/4", a_rd_after_idx, a_rd_after_way); end
    checks++; if (a_ack_cyc - a_start_cyc + 1 != 6156) begin failures++; $display("FAIL dirty_ack_latency got=%0d want=6156", a_ack_cyc - a_start_cyc + 1); end
    $display("dirty_line: wb=%0d at %0d/%0d resume=%0d/%0d", a_wb_cnt, a_wb_last_idx, a_wb_last_way, a_rd_after_idx, a_rd_after_way);
  endtask

  task automatic test_backpressure();
    int n;
    fill_a_clean(); clear_a_counters();
    a_bp = 1;
    pulse_a_flush();
    wait_a_done(30000, n);
    a_bp = 0;
    checks++; if (a_rd_cnt != 2048 || a_wr_cnt != 2048) begin failures++; $display("FAIL bp_totals got=%0d/%0d want=2048/2048", a_rd_cnt, a_wr_cnt); end
    checks++; if (a_stab_err != 0) begin failures++; $display("FAIL bp_stable got=%0d want=0", a_stab_err); end
    checks++; if (a_ack_cnt != 1 || a_wr_bad != 0) begin failures++; $display("FAIL bp_ack got=%0d bad=%0d want=1 bad=0", a_ack_cnt, a_wr_bad); end
    $display("backpressure: reads=%0d writes=%0d unstable=%0d", a_rd_cnt, a_wr_cnt, a_stab_err);
  endtask

  task automatic test_noinv_mix();
    int n;
    for (int s = 0; s < 4; s++) for (int w = 0; w < 2; w++) begin b_mem_v[s][w] = 0; b_mem_d[s][w] = 0; end
    b_mem_v[0][0] = 1;
    b_mem_v[0][1] = 1; b_mem_d[0][1] = 1;
    b_mem_d[1][0] = 1;
    b_mem_v[2][0] = 1; b_mem_d[2][0] = 1;
    b_mem_v[3][1] = 1;
    b_rd_cnt = 0; b_wr_cnt = 0; b_wr_bad = 0; b_wb_cnt = 0; b_ack_cnt = 0;
    @(posedge clk); #1 b_flush = 1;
    @(posedge clk); #1 b_flush = 0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(b_ack_cnt > 0 && !b_busy) && n < 200);
    checks++; if (b_rd_cnt != 8) begin failures++; $display("FAIL noinv_reads got=%0d want=8", b_rd_cnt); end
    checks++; if (b_wr_cnt != 2 || b_wr_bad != 0) begin failures++; $display("FAIL noinv_writes got=%0d bad=%0d want=2 bad=0", b_wr_cnt, b_wr_bad); end
    checks++; if (b_wb_cnt != 2) begin failures++; $display("FAIL noinv_wb_reqs got=%0d want=2", b_wb_cnt); end
    checks++; if (!b_mem_v[0][1] || b_mem_d[0][1] || !b_mem_v[3][1]) begin failures++; $display("FAIL noinv_state got=%0b%0b%0b want=101", b_mem_v[0][1], b_mem_d[0][1], b_mem_v[3][1]); end
    checks++; if (b_ack_cyc - b_start_cyc + 1 != 41) begin failures++; $display("FAIL noinv_ack_latency got=%0d want=41", b_ack_cyc - b_start_cyc + 1); end
    $display("noinv_mix: reads=%0d writes=%0d wb=%0d", b_rd_cnt, b_wr_cnt, b_wb_cnt);
  endtask

  task automatic test_rst_mid_wb();
    int n, wr_before;
    fill_a_clean(); a_mem_d[100][0] = 1; clear_a_counters();
    pulse_a_flush();
    n = 0;
    do begin @(negedge clk); #1; n++; end while (a_wb_cnt == 0 && n < 7000);
    checks++; if (a_wb_last_idx != 8'd100) begin failures++; $display("FAIL rstwb_wb_idx got=%0d want=100", a_wb_last_idx); end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 a_init_cnt = 0; a_init_exp = 0; a_init_bad = 0; rst = 0;
    wait_a_idle(400, n);
    checks++; if (n != 257 || a_init_cnt != 256) begin failures++; $display("FAIL rstwb_reinit got=%0d/%0d want=257/256", n, a_init_cnt); end
    wr_before = a_wr_cnt;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (a_ack_cnt != 0) begin failures++; $display("FAIL rstwb_no_ack got=%0d want=0", a_ack_cnt); end
    checks++; if (a_busy !== 1'b0 || a_wr_cnt != wr_before || a_wb_timer != 0) begin failures++; $display("FAIL rstwb_stale_done got=busy%0b wr%0d want=busy0 wr%0d", a_busy, a_wr_cnt, wr_before); end
    $display("rst_mid_wb: reinit_writes=%0d acks=%0d", a_init_cnt, a_ack_cnt);
  endtask

  task automatic test_back_to_back();
    int n, ack1, ack2;
    ack1 = 0; ack2 = 0;
    @(posedge clk); #1 rst = 1; b_flush = 1;
    @(posedge clk); #1 rst = 0;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
      if (b_ack) begin if (ack1 == 0) ack1 = n; else ack2 = n; end
    end while (ack2 == 0 && n < 100);
    @(posedge clk); #1 b_flush = 0;
    checks++; if (ack1 != 22) begin failures++; $display("FAIL b2b_first_ack got=%0d want=22", ack1); end
    checks++; if (ack2 != 40) begin failures++; $display("FAIL b2b_second_ack got=%0d want=40", ack2); end
    wait_a_idle(400, n);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (b_busy !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL b2b_settle got=%0b/%0b want=0/0", b_busy, a_busy); end
    $display("back_to_back: acks at cycles %0d and %0d", ack1, ack2);
  endtask

  initial begin
    test_reset();
    test_init();
    test_inv_flush();
    test_dirty_line();
    test_backpressure();
    test_noinv_mix();
    test_rst_mid_wb();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
